// File: rtl/phase_seq_monitor.sv
// Monitors the phase codes of an upstream 1->2->(3)->4->1 Moore sequencer.
// It tracks lock, counts completed cycles, phase-3 skips and illegal transitions.
module phase_seq_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       phase_in,
    input  logic             phase_valid,
    input  logic             clear,
    output logic             lock,
    output logic [2:0]       last_phase,
    output logic             cycle_done,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] skip_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t             state_r;
    logic               lock_r;
    logic [2:0]         last_phase_r;
    logic               cycle_done_r;
    logic               err_pulse_r;
    logic [CNT_W-1:0]   cycle_count_r;
    logic [CNT_W-1:0]   skip_count_r;
    logic [CNT_W-1:0]   err_count_r;

    logic               legal_s;
    logic               wrap_s;
    logic               skip_s;

    function automatic logic is_legal(input logic [2:0] prev, input logic [2:0] cur);
        logic ok;
        case ({prev, cur})
            {3'd1, 3'd2}: ok = 1'b1;
            {3'd2, 3'd3}: ok = 1'b1;
            {3'd2, 3'd4}: ok = 1'b1;
            {3'd3, 3'd4}: ok = 1'b1;
            {3'd4, 3'd1}: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign legal_s = is_legal(last_phase_r, phase_in);
    assign wrap_s  = (last_phase_r == 3'd4) && (phase_in == 3'd1);
    assign skip_s  = (last_phase_r == 3'd2) && (phase_in == 3'd4);

    // Tracker FSM, pulses and event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= UNLOCKED;
            lock_r        <= 1'b0;
            last_phase_r  <= 3'd0;
            cycle_done_r  <= 1'b0;
            err_pulse_r   <= 1'b0;
            cycle_count_r <= {CNT_W{1'b0}};
            skip_count_r  <= {CNT_W{1'b0}};
            err_count_r   <= {CNT_W{1'b0}};
        end else if (clear) begin
            state_r       <= UNLOCKED;
            lock_r        <= 1'b0;
            last_phase_r  <= 3'd0;
            cycle_done_r  <= 1'b0;
            err_pulse_r   <= 1'b0;
            cycle_count_r <= {CNT_W{1'b0}};
            skip_count_r  <= {CNT_W{1'b0}};
            err_count_r   <= {CNT_W{1'b0}};
        end else begin
            cycle_done_r <= 1'b0;
            err_pulse_r  <= 1'b0;
            if (phase_valid) begin
                case (state_r)
                    UNLOCKED: begin
                        if (phase_in == 3'd1) begin
                            state_r      <= LOCKED;
                            lock_r       <= 1'b1;
                            last_phase_r <= 3'd1;
                        end
                    end
                    LOCKED: begin
                        if (legal_s) begin
                            last_phase_r <= phase_in;
                            if (wrap_s) begin
                                cycle_done_r  <= 1'b1;
                                cycle_count_r <= sat_inc(cycle_count_r);
                            end
                            if (skip_s) begin
                                skip_count_r <= sat_inc(skip_count_r);
                            end
                        end else begin
                            err_pulse_r <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            // A stray 1 is taken as the start of a new cycle.
                            if (phase_in == 3'd1) begin
                                last_phase_r <= 3'd1;
                            end else begin
                                state_r <= UNLOCKED;
                                lock_r  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r <= UNLOCKED;
                        lock_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lock        = lock_r;
    assign last_phase  = last_phase_r;
    assign cycle_done  = cycle_done_r;
    assign err_pulse   = err_pulse_r;
    assign cycle_count = cycle_count_r;
    assign skip_count  = skip_count_r;
    assign err_count   = err_count_r;

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Directed-vector bench for phase_seq_monitor; expectations are queued as stimulus
// is applied and a negedge monitor compares them against the outputs.
module tb_phase_seq_monitor;

    logic       clk;
    logic       reset;
    logic [2:0] phase_in;
    logic       phase_valid;
    logic       clear;
    logic       lock;
    logic [2:0] last_phase;
    logic       cycle_done;
    logic       err_pulse;
    logic [7:0] cycle_count;
    logic [7:0] skip_count;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      nm;
        logic [29:0] val;
    } exp_t;

    exp_t q[$];

    phase_seq_monitor #(.CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .phase_in    (phase_in),
        .phase_valid (phase_valid),
        .clear       (clear),
        .lock        (lock),
        .last_phase  (last_phase),
        .cycle_done  (cycle_done),
        .err_pulse   (err_pulse),
        .cycle_count (cycle_count),
        .skip_count  (skip_count),
        .err_count   (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [29:0] pack(input logic lk, input logic [2:0] lp, input logic cd,
                                         input logic ep, input int cc, input int sc, input int ec);
        logic [7:0] c8, s8, e8;
        c8 = cc[7:0];
        s8 = sc[7:0];
        e8 = ec[7:0];
        return {lk, lp, cd, ep, c8, s8, e8};
    endfunction

    task automatic check(input string nm, input logic [29:0] exp_v);
        logic [29:0] act;
        act = {lock, last_phase, cycle_done, err_pulse, cycle_count, skip_count, err_count};
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got lock=%0b last=%0d cd=%0b ep=%0b cc=%0d sc=%0d ec=%0d, expected lock=%0b last=%0d cd=%0b ep=%0b cc=%0d sc=%0d ec=%0d",
                     nm, act[29], act[28:26], act[25], act[24], act[23:16], act[15:8], act[7:0],
                     exp_v[29], exp_v[28:26], exp_v[25], exp_v[24], exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
    endtask

    // Monitor: compares one queued expectation per clock, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.nm, e.val);
        end
    end

    task automatic step(input logic v, input logic [2:0] p, input logic c, input string nm,
                        input logic lk, input logic [2:0] lp, input logic cd, input logic ep,
                        input int cc, input int sc, input int ec);
        exp_t e;
        phase_valid = v;
        phase_in    = p;
        clear       = c;
        @(posedge clk);
        #1;
        e.nm  = nm;
        e.val = pack(lk, lp, cd, ep, cc, sc, ec);
        q.push_back(e);
        phase_valid = 1'b0;
        clear       = 1'b0;
    endtask

    initial begin
        int cc_e;
        reset       = 1'b1;
        phase_in    = 3'd0;
        phase_valid = 1'b0;
        clear       = 1'b0;
        #2;
        check("reset_state", pack(1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0));
        #5;
        reset = 1'b0;

        // 1,2,3,4,1 full cycle
        step(1'b1, 3'd1, 1'b0, "a_lock",  1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd2, 1'b0, "a_p2",    1'b1, 3'd2, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd3, 1'b0, "a_p3",    1'b1, 3'd3, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd4, 1'b0, "a_p4",    1'b1, 3'd4, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd1, 1'b0, "a_wrap",  1'b1, 3'd1, 1'b1, 1'b0, 1, 0, 0);
        step(1'b0, 3'd3, 1'b0, "a_idle",  1'b1, 3'd1, 1'b0, 1'b0, 1, 0, 0);
        step(1'b0, 3'd0, 1'b1, "a_clear", 1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);

        // 1,2,4,1 skip path
        step(1'b1, 3'd1, 1'b0, "b_lock",  1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd2, 1'b0, "b_p2",    1'b1, 3'd2, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd4, 1'b0, "b_skip",  1'b1, 3'd4, 1'b0, 1'b0, 0, 1, 0);
        step(1'b1, 3'd1, 1'b0, "b_wrap",  1'b1, 3'd1, 1'b1, 1'b0, 1, 1, 0);
        step(1'b0, 3'd0, 1'b1, "b_clear", 1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);

        // 1,3,2,1 illegal drop to unlocked
        step(1'b1, 3'd1, 1'b0, "c_lock",   1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd3, 1'b0, "c_err",    1'b0, 3'd1, 1'b0, 1'b1, 0, 0, 1);
        step(1'b1, 3'd2, 1'b0, "c_ignore", 1'b0, 3'd1, 1'b0, 1'b0, 0, 0, 1);
        step(1'b1, 3'd1, 1'b0, "c_relock", 1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 1);
        step(1'b0, 3'd0, 1'b1, "c_clear",  1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);

        // 1,2,1 resync, then repeats and out-of-range codes
        step(1'b1, 3'd1, 1'b0, "d_lock",    1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd2, 1'b0, "d_p2",      1'b1, 3'd2, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd1, 1'b0, "d_resync",  1'b1, 3'd1, 1'b0, 1'b1, 0, 0, 1);
        step(1'b1, 3'd2, 1'b0, "d_after",   1'b1, 3'd2, 1'b0, 1'b0, 0, 0, 1);
        step(1'b1, 3'd2, 1'b0, "d_repeat",  1'b0, 3'd2, 1'b0, 1'b1, 0, 0, 2);
        step(1'b1, 3'd5, 1'b0, "d_ign5",    1'b0, 3'd2, 1'b0, 1'b0, 0, 0, 2);
        step(1'b1, 3'd1, 1'b0, "d_relock",  1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 2);
        step(1'b1, 3'd7, 1'b0, "d_code7",   1'b0, 3'd1, 1'b0, 1'b1, 0, 0, 3);
        step(1'b1, 3'd1, 1'b0, "d_relock2", 1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 3);
        step(1'b1, 3'd0, 1'b0, "d_code0",   1'b0, 3'd1, 1'b0, 1'b1, 0, 0, 4);
        step(1'b0, 3'd0, 1'b1, "d_clear",   1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);

        // clear beats a valid 4->1 on the same edge
        step(1'b1, 3'd1, 1'b0, "e_lock",   1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd2, 1'b0, "e_p2",     1'b1, 3'd2, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd3, 1'b0, "e_p3",     1'b1, 3'd3, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd4, 1'b0, "e_p4",     1'b1, 3'd4, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd1, 1'b1, "e_clrwrp", 1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd2, 1'b0, "e_ign2",   1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);

        // 300 cycles with valid toggling: cycle_count saturates at 255
        for (int k = 0; k < 300; k++) begin
            cc_e = (k > 255) ? 255 : k;
            for (int p = 1; p <= 4; p++) begin
                step(1'b1, 3'(p), 1'b0, "f_sat", 1'b1, 3'(p), (p == 1 && k > 0), 1'b0, cc_e, 0, 0);
                step(1'b0, 3'd6, 1'b0, "f_hold", 1'b1, 3'(p), 1'b0, 1'b0, cc_e, 0, 0);
            end
        end
        step(1'b1, 3'd1, 1'b0, "f_satwrap", 1'b1, 3'd1, 1'b1, 1'b0, 255, 0, 0);

        // reset between edges mid-sequence, then relock needs a fresh 1
        step(1'b1, 3'd2, 1'b0, "g_p2",     1'b1, 3'd2, 1'b0, 1'b0, 255, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", pack(1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 3'd3, 1'b0, "g_ign3",   1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 3'd1, 1'b0, "g_relock", 1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            if (q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
